// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg                                                                |
// | Shared types and defaults for the single-port memory arbiter.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int MAX_DATA_RUN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pick                                                               |
// | Data-over-fetch priority picker with a forced fetch after a data run.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEFAULT
) (
  input  logic       f_req,
  input  logic       d_req,
  input  logic [3:0] run_cnt,
  output logic       grant_f,
  output logic       grant_d
);

  logic w_fetch_forced;

  assign w_fetch_forced = f_req && (run_cnt == 4'(MAX_DATA_RUN));
  assign grant_d        = d_req && !w_fetch_forced;
  assign grant_f        = f_req && !grant_d;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one req/ack/rvalid memory port between fetch and data requesters.   |
// | Optional performance counters: define ARB_PERF_CNT_EN.                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEFAULT,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_req,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  output logic [31:0]       perf_f_cnt,
  output logic [31:0]       perf_d_cnt,
  output logic [31:0]       perf_wait_cnt
);

  state_t            r_state;
  owner_t            r_owner;
  logic [3:0]        r_run_cnt;
  logic              r_m_req;
  logic [3:0]        r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       r_m_wdata;
  logic              r_f_rvalid;
  logic              r_d_rvalid;
  logic [31:0]       r_f_rdata;
  logic [31:0]       r_d_rdata;

  logic w_pick_f;
  logic w_pick_d;
  logic w_idle;
  logic w_grant_f;
  logic w_grant_d;
  logic w_done;
  logic [3:0] w_run_max;

  mem_arb_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .f_req   (f_req),
    .d_req   (d_req),
    .run_cnt (r_run_cnt),
    .grant_f (w_pick_f),
    .grant_d (w_pick_d)
  );

  assign w_run_max = 4'(MAX_DATA_RUN);
  assign w_idle    = (r_state == IDLE);
  // Grants are combinational, so gate them with reset to keep outputs low while in reset.
  assign w_grant_f = rst_n && w_idle && w_pick_f;
  assign w_grant_d = rst_n && w_idle && w_pick_d;
  assign w_done    = ((r_state == ISSUE) && m_ack && m_rvalid) ||
                     ((r_state == WAIT) && m_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= NONE;
      r_run_cnt  <= 4'd0;
      r_m_req    <= 1'b0;
      r_m_we     <= 4'd0;
      r_m_addr   <= '0;
      r_m_wdata  <= 32'd0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_req   <= 1'b1;
            r_owner   <= DATA;
            r_state   <= ISSUE;
            if (f_req) begin
              r_run_cnt <= (r_run_cnt == w_run_max) ? r_run_cnt : r_run_cnt + 4'd1;
            end else begin
              r_run_cnt <= 4'd0;
            end
          end else if (w_grant_f) begin
            r_m_we    <= 4'd0;
            r_m_addr  <= f_addr;
            r_m_wdata <= 32'd0;
            r_m_req   <= 1'b1;
            r_owner   <= FETCH;
            r_state   <= ISSUE;
            r_run_cnt <= 4'd0;
          end
        end
        ISSUE: begin
          if (m_ack) begin
            r_m_req <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
        end
        default: r_state <= IDLE;
      endcase
      // Completion overrides the ISSUE->WAIT move when ack and response coincide.
      if (w_done) begin
        r_state <= IDLE;
        r_owner <= NONE;
        if (r_owner == FETCH) begin
          r_f_rvalid <= 1'b1;
          r_f_rdata  <= m_rdata;
        end else if (r_owner == DATA) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= m_rdata;
        end
      end
    end
  end

  assign f_gnt    = w_grant_f;
  assign d_gnt    = w_grant_d;
  assign f_rvalid = r_f_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign f_rdata  = r_f_rdata;
  assign d_rdata  = r_d_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_f;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_f    <= 32'd0;
      r_perf_d    <= 32'd0;
      r_perf_wait <= 32'd0;
    end else begin
      if (w_grant_f) r_perf_f <= r_perf_f + 32'd1;
      if (w_grant_d) r_perf_d <= r_perf_d + 32'd1;
      if (!w_idle && (f_req || d_req)) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_f_cnt    = r_perf_f;
  assign perf_d_cnt    = r_perf_d;
  assign perf_wait_cnt = r_perf_wait;
`else
  assign perf_f_cnt    = 32'd0;
  assign perf_d_cnt    = 32'd0;
  assign perf_wait_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
